// File: rtl/xbar_pipe.sv
// Pipelined distribution crossbar: routes any input element to each PE lane
// through a two-stage elastic pipeline with a per-beat config snapshot.
module xbar_pipe #(
    parameter int DATA_TYPE = 16,
    parameter int NUM_PES   = 32,
    parameter int INPUT_BW  = 32,
    parameter int SEL_W     = 6,
    parameter int CNT_W     = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_cfg_valid,
    input  logic [NUM_PES*SEL_W-1:0]      i_mux_bus,
    input  logic [NUM_PES-1:0]            i_pe_mask,
    input  logic                          i_data_valid,
    output logic                          o_data_ready,
    input  logic [INPUT_BW*DATA_TYPE-1:0] i_data_bus,
    output logic                          o_dist_valid,
    input  logic                          i_dist_ready,
    output logic [NUM_PES*DATA_TYPE-1:0]  o_dist_bus,
    output logic [NUM_PES-1:0]            o_pe_valid,
    output logic [NUM_PES-1:0]            o_sel_err,
    output logic [CNT_W-1:0]              o_beat_cnt
);

    localparam int SELBUS_W = NUM_PES * SEL_W;
    localparam int DIN_W    = INPUT_BW * DATA_TYPE;
    localparam int DOUT_W   = NUM_PES * DATA_TYPE;
    localparam logic [SEL_W:0] SEL_LIMIT = (SEL_W + 1)'(INPUT_BW);

    logic [SELBUS_W-1:0] cfg_sel_q;
    logic [NUM_PES-1:0]  cfg_mask_q;

    logic                s1_v_q;
    logic [DIN_W-1:0]    s1_data_q;
    logic [SELBUS_W-1:0] s1_sel_q;
    logic [NUM_PES-1:0]  s1_mask_q;

    logic                s2_v_q;
    logic [DOUT_W-1:0]   s2_data_q;
    logic [NUM_PES-1:0]  s2_pev_q;
    logic [NUM_PES-1:0]  s2_err_q;

    logic [CNT_W-1:0]    cnt_q;

    logic [DOUT_W-1:0]   lane_data_d;
    logic [NUM_PES-1:0]  lane_pev_d;
    logic [NUM_PES-1:0]  lane_err_d;

    logic out_fire;
    logic s2_adv;
    logic accept;

    assign out_fire     = s2_v_q && i_dist_ready;
    assign s2_adv       = s1_v_q && (!s2_v_q || out_fire);
    assign o_data_ready = !s1_v_q || s2_adv;
    assign accept       = i_data_valid && o_data_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int p = 0; p < NUM_PES; p++) begin
                cfg_sel_q[p*SEL_W +: SEL_W] <= SEL_W'(p % INPUT_BW);
            end
            cfg_mask_q <= '1;
        end else if (i_cfg_valid) begin
            cfg_sel_q  <= i_mux_bus;
            cfg_mask_q <= i_pe_mask;
        end
    end

    // S1 captures the config registers as they were before this edge, so a
    // config load on the accepting edge only affects later beats.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_v_q    <= 1'b0;
            s1_data_q <= '0;
            s1_sel_q  <= '0;
            s1_mask_q <= '0;
        end else if (accept) begin
            s1_v_q    <= 1'b1;
            s1_data_q <= i_data_bus;
            s1_sel_q  <= cfg_sel_q;
            s1_mask_q <= cfg_mask_q;
        end else if (s2_adv) begin
            s1_v_q <= 1'b0;
        end
    end

    always_comb begin
        logic [SEL_W-1:0] sel;
        lane_data_d = '0;
        lane_pev_d  = '0;
        lane_err_d  = '0;
        sel         = '0;
        for (int p = 0; p < NUM_PES; p++) begin
            sel = s1_sel_q[p*SEL_W +: SEL_W];
            if (s1_mask_q[p]) begin
                if ({1'b0, sel} >= SEL_LIMIT) begin
                    lane_err_d[p] = 1'b1;
                end else begin
                    lane_pev_d[p] = 1'b1;
                    for (int k = 0; k < INPUT_BW; k++) begin
                        if (sel == SEL_W'(k)) begin
                            lane_data_d[p*DATA_TYPE +: DATA_TYPE] = s1_data_q[k*DATA_TYPE +: DATA_TYPE];
                        end
                    end
                end
            end
        end
    end

    // Lane valids are dropped when S2 empties so they never outlive o_dist_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_v_q    <= 1'b0;
            s2_data_q <= '0;
            s2_pev_q  <= '0;
            s2_err_q  <= '0;
        end else if (s2_adv) begin
            s2_v_q    <= 1'b1;
            s2_data_q <= lane_data_d;
            s2_pev_q  <= lane_pev_d;
            s2_err_q  <= lane_err_d;
        end else if (out_fire) begin
            s2_v_q   <= 1'b0;
            s2_pev_q <= '0;
            s2_err_q <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (out_fire) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign o_dist_valid = s2_v_q;
    assign o_dist_bus   = s2_data_q;
    assign o_pe_valid   = s2_pev_q;
    assign o_sel_err    = s2_err_q;
    assign o_beat_cnt   = cnt_q;

endmodule

// File: tb/tb_xbar_pipe.sv
// Scoreboard bench for xbar_pipe: a config/routing model predicts each
// accepted beat, and predictions are compared as beats leave the pipeline.
module tb_xbar_pipe;

    localparam int DW   = 16;
    localparam int NP   = 32;
    localparam int IBW  = 32;
    localparam int SW   = 6;
    localparam int CW   = 32;
    localparam int DIN  = IBW * DW;
    localparam int DOUT = NP * DW;

    typedef struct {
        logic [DOUT-1:0] bus;
        logic [NP-1:0]   pev;
        logic [NP-1:0]   err;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             i_cfg_valid;
    logic [NP*SW-1:0] i_mux_bus;
    logic [NP-1:0]    i_pe_mask;
    logic             i_data_valid;
    logic             o_data_ready;
    logic [DIN-1:0]   i_data_bus;
    logic             o_dist_valid;
    logic             i_dist_ready;
    logic [DOUT-1:0]  o_dist_bus;
    logic [NP-1:0]    o_pe_valid;
    logic [NP-1:0]    o_sel_err;
    logic [CW-1:0]    o_beat_cnt;

    int checks;
    int failures;
    exp_t sbq[$];
    logic [NP*SW-1:0] mSel;
    logic [NP-1:0]    mMask;

    xbar_pipe #(
        .DATA_TYPE(DW), .NUM_PES(NP), .INPUT_BW(IBW), .SEL_W(SW), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .i_cfg_valid(i_cfg_valid), .i_mux_bus(i_mux_bus), .i_pe_mask(i_pe_mask),
        .i_data_valid(i_data_valid), .o_data_ready(o_data_ready), .i_data_bus(i_data_bus),
        .o_dist_valid(o_dist_valid), .i_dist_ready(i_dist_ready), .o_dist_bus(o_dist_bus),
        .o_pe_valid(o_pe_valid), .o_sel_err(o_sel_err), .o_beat_cnt(o_beat_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [DOUT-1:0] obs, input logic [DOUT-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NP*SW-1:0] defaultSel();
        logic [NP*SW-1:0] s;
        for (int p = 0; p < NP; p++) s[p*SW +: SW] = SW'(p % IBW);
        return s;
    endfunction

    function automatic exp_t route(input logic [DIN-1:0] d, input logic [NP*SW-1:0] s, input logic [NP-1:0] m);
        exp_t e;
        e.bus = '0;
        e.pev = '0;
        e.err = '0;
        for (int p = 0; p < NP; p++) begin
            int sv;
            sv = int'(s[p*SW +: SW]);
            if (m[p]) begin
                if (sv >= IBW) e.err[p] = 1'b1;
                else begin
                    e.pev[p] = 1'b1;
                    e.bus[p*DW +: DW] = d[sv*DW +: DW];
                end
            end
        end
        return e;
    endfunction

    // Outputs are compared before the edge that hands them off; a beat is
    // predicted before the edge that accepts it, using the pre-load config.
    always @(negedge clk) begin
        if (!rst) begin
            sbq.delete();
            mSel  = defaultSel();
            mMask = '1;
        end else begin
            if (!o_dist_valid) checkOutput("pev_idle", o_pe_valid, '0);
            if (o_dist_valid && i_dist_ready) begin
                if (sbq.size() == 0) checkOutput("unexpected_beat", o_dist_valid, 1'b0);
                else begin
                    exp_t e;
                    e = sbq.pop_front();
                    checkOutput("beat_bus", o_dist_bus, e.bus);
                    checkOutput("beat_pev", o_pe_valid, e.pev);
                    checkOutput("beat_err", o_sel_err, e.err);
                end
            end
            if (i_data_valid && o_data_ready) sbq.push_back(route(i_data_bus, mSel, mMask));
            if (i_cfg_valid) begin
                mSel  = i_mux_bus;
                mMask = i_pe_mask;
            end
        end
    end

    task automatic doReset();
        rst          = 1'b0;
        i_cfg_valid  = 1'b0;
        i_data_valid = 1'b0;
        i_data_bus   = '0;
        i_mux_bus    = '0;
        i_pe_mask    = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic applyStimulus(input logic [DIN-1:0] d, output int stalls);
        logic rdy;
        i_data_valid = 1'b1;
        i_data_bus   = d;
        stalls       = 0;
        forever begin
            @(negedge clk);
            rdy = o_data_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            stalls++;
            if (stalls > 50) begin
                checkOutput("accept_timeout", o_data_ready, 1'b1);
                break;
            end
        end
        i_data_valid = 1'b0;
    endtask

    task automatic applyConfig(input logic [NP*SW-1:0] s, input logic [NP-1:0] m);
        i_cfg_valid = 1'b1;
        i_mux_bus   = s;
        i_pe_mask   = m;
        @(posedge clk);
        #1 i_cfg_valid = 1'b0;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 100 && sbq.size() != 0; i++) @(posedge clk);
        #1 checkOutput("drain", sbq.size(), 0);
    endtask

    task automatic waitValid();
        for (int i = 0; i < 50 && !o_dist_valid; i++) @(posedge clk);
        @(negedge clk);
        if (!o_dist_valid) checkOutput("valid_timeout", o_dist_valid, 1'b1);
    endtask

    initial begin
        logic [DIN-1:0]   d;
        logic [NP*SW-1:0] s;
        logic [NP-1:0]    m;
        int st;
        int stallSum;
        checks   = 0;
        failures = 0;
        i_dist_ready = 1'b1;
        doReset();

        @(negedge clk);
        checkOutput("rst_valid", o_dist_valid, 1'b0);
        checkOutput("rst_ready", o_data_ready, 1'b1);
        checkOutput("rst_cnt", o_beat_cnt, '0);
        checkOutput("rst_bus", o_dist_bus, '0);
        checkOutput("rst_pev", o_pe_valid, '0);
        checkOutput("rst_err", o_sel_err, '0);
        @(posedge clk);
        #1;

        $display("[TB] reset config routing and latency");
        for (int k = 0; k < IBW; k++) d[k*DW +: DW] = DW'(k + 100);
        applyStimulus(d, st);
        checkOutput("lat_early", o_dist_valid, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("lat_valid", o_dist_valid, 1'b1);
        checkOutput("lane31", o_dist_bus[31*DW +: DW], DW'(131));
        checkOutput("lane0", o_dist_bus[0 +: DW], DW'(100));
        checkOutput("pev_all", o_pe_valid, {NP{1'b1}});
        @(posedge clk);
        #1;
        checkOutput("cnt_one", o_beat_cnt, CW'(1));
        checkOutput("valid_done", o_dist_valid, 1'b0);

        $display("[TB] broadcast stream");
        doReset();
        for (int p = 0; p < NP; p++) s[p*SW +: SW] = SW'(7);
        applyConfig(s, '1);
        stallSum = 0;
        for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < IBW; k++) d[k*DW +: DW] = DW'($urandom_range(1, 65535));
            d[7*DW +: DW] = DW'(b);
            applyStimulus(d, st);
            stallSum += st;
        end
        checkOutput("bcast_stalls", stallSum, 0);
        waitDrain();
        checkOutput("bcast_cnt", o_beat_cnt, CW'(10));

        $display("[TB] backpressure");
        doReset();
        i_dist_ready = 1'b0;
        fork
            begin
                for (int b = 0; b < 3; b++) begin
                    for (int k = 0; k < IBW; k++) d[k*DW +: DW] = DW'(k * 3 + b * 1000 + 1);
                    applyStimulus(d, st);
                end
            end
            begin
                repeat (3) @(posedge clk);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    checkOutput("bp_ready", o_data_ready, 1'b0);
                    checkOutput("bp_valid", o_dist_valid, 1'b1);
                    if (sbq.size() != 0) begin
                        checkOutput("bp_hold_bus", o_dist_bus, sbq[0].bus);
                        checkOutput("bp_hold_pev", o_pe_valid, sbq[0].pev);
                    end
                end
                @(posedge clk);
                #1 i_dist_ready = 1'b1;
            end
        join
        waitDrain();
        checkOutput("bp_cnt", o_beat_cnt, CW'(3));

        $display("[TB] out-of-range select and mask");
        doReset();
        s = defaultSel();
        s[3*SW +: SW] = SW'(40);
        m = '1;
        m[5] = 1'b0;
        applyConfig(s, m);
        i_dist_ready = 1'b0;
        for (int k = 0; k < IBW; k++) d[k*DW +: DW] = DW'($urandom_range(1, 65535));
        applyStimulus(d, st);
        waitValid();
        checkOutput("oor_lane3", o_dist_bus[3*DW +: DW], '0);
        checkOutput("oor_err3", o_sel_err[3], 1'b1);
        checkOutput("oor_pev3", o_pe_valid[3], 1'b0);
        checkOutput("mask_lane5", o_dist_bus[5*DW +: DW], '0);
        checkOutput("mask_pev5", o_pe_valid[5], 1'b0);
        checkOutput("mask_err5", o_sel_err[5], 1'b0);
        checkOutput("norm_lane4", o_dist_bus[4*DW +: DW], d[4*DW +: DW]);
        i_dist_ready = 1'b1;
        waitDrain();

        $display("[TB] config race");
        doReset();
        for (int p = 0; p < NP; p++) s[p*SW +: SW] = SW'(1);
        i_cfg_valid = 1'b1;
        i_mux_bus   = s;
        i_pe_mask   = '1;
        for (int k = 0; k < IBW; k++) d[k*DW +: DW] = DW'(k + 200);
        applyStimulus(d, st);
        i_cfg_valid = 1'b0;
        for (int k = 0; k < IBW; k++) d[k*DW +: DW] = DW'(k + 300);
        applyStimulus(d, st);
        waitDrain();

        $display("[TB] async reset mid-stream");
        doReset();
        for (int k = 0; k < IBW; k++) d[k*DW +: DW] = DW'(k + 500);
        applyStimulus(d, st);
        waitDrain();
        i_dist_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < IBW; k++) d[k*DW +: DW] = DW'(k + 600 + b);
            applyStimulus(d, st);
        end
        @(negedge clk);
        checkOutput("ar_full", o_data_ready, 1'b0);
        #2 rst = 1'b0;
        #1;
        checkOutput("ar_valid", o_dist_valid, 1'b0);
        checkOutput("ar_cnt", o_beat_cnt, '0);
        checkOutput("ar_bus", o_dist_bus, '0);
        checkOutput("ar_pev", o_pe_valid, '0);
        checkOutput("ar_ready", o_data_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        i_dist_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checkOutput("ar_no_stale", o_dist_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < IBW; k++) d[k*DW +: DW] = DW'(k + 700);
        applyStimulus(d, st);
        waitDrain();
        checkOutput("ar_cnt_after", o_beat_cnt, CW'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/xbar_pipe.md
Name: xbar_pipe

Overview:
- Next-generation distribution crossbar: routes any of INPUT_BW input elements to each of NUM_PES multiplier lanes, with multicast allowed.
- Adds over the basic crossbar:
  - a registered configuration (select and lane mask) that is snapshotted per beat;
  - a two-stage elastic pipeline with valid/ready handshakes on input and output;
  - out-of-range select detection;
  - a delivered-beat counter.
- Sits between the input SRAM/buffer read port and the multiplier array.

Parameters:
- DATA_TYPE, 16, element width in bits
- NUM_PES, 32, number of output lanes
- INPUT_BW, 32, number of input elements per beat
- SEL_W, 6, select width per lane; must satisfy 2^SEL_W >= INPUT_BW, and values >= INPUT_BW are legal inputs
- CNT_W, 32, beat counter width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- i_cfg_valid  in  1  load i_mux_bus and i_pe_mask into the config registers
- i_mux_bus  in  NUM_PES*SEL_W  lane p select is bits [p*SEL_W +: SEL_W]
- i_pe_mask  in  NUM_PES  lane enable; 1 = lane driven
- i_data_valid  in  1  input beat valid
- o_data_ready  out  1  block can accept a beat
- i_data_bus  in  INPUT_BW*DATA_TYPE  element k is bits [k*DATA_TYPE +: DATA_TYPE]
- o_dist_valid  out  1  output beat valid
- i_dist_ready  in  1  downstream accepts the output beat
- o_dist_bus  out  NUM_PES*DATA_TYPE  routed elements
- o_pe_valid  out  NUM_PES  per-lane valid: mask AND o_dist_valid AND NOT sel_err
- o_sel_err  out  NUM_PES  lane select was >= INPUT_BW for this beat
- o_beat_cnt  out  CNT_W  count of output beats handed off

Behaviour:
- Reset (rst low, asynchronous):
  - stage valids cleared, so o_dist_valid = 0 and o_data_ready = 1;
  - o_dist_bus, o_pe_valid, o_sel_err and o_beat_cnt all = 0;
  - config select for lane p = p mod INPUT_BW; mask = all ones.
- Reset mid-operation: all in-flight beats are discarded; no partial output is presented after reset is released.
- Config:
  - i_cfg_valid high at a clock edge loads the config registers on that edge.
  - A beat accepted on the same edge uses the OLD config; beats accepted on later edges use the new config.
  - A config change never alters beats already in the pipeline.
- Input acceptance: a beat is accepted when i_data_valid && o_data_ready at a rising edge.
- Stage 1 (S1): on acceptance, register i_data_bus together with a snapshot of the current select and mask; s1_v = 1.
- Stage 2 (S2): on advance, compute per lane from the S1 contents and register the results; s2_v = 1.
  - sel_err = (sel >= INPUT_BW);
  - data = sel_err ? 0 : element[sel];
  - if mask = 0, lane data = 0 and sel_err = 0;
  - o_pe_valid = mask && !sel_err.
- Elastic pipeline control:
  - out_fire = s2_v && i_dist_ready
  - s2_adv = s1_v && (!s2_v || out_fire)
  - o_data_ready = !s1_v || s2_adv (combinational; no combinational path from i_data_valid)
  - S2 clears when out_fire && !s2_adv; S1 clears when s2_adv && !accept.
- Latency and throughput:
  - A beat accepted at edge T is presented at o_dist_valid after edge T+1, i.e. on the cycle after its S2 load.
  - Throughput is 1 beat/cycle while i_dist_ready stays high.
- Stalls:
  - While o_dist_valid && !i_dist_ready, o_dist_bus, o_pe_valid and o_sel_err hold stable.
  - Maximum occupancy is 2 beats; when both stages are full and i_dist_ready = 0, o_data_ready = 0.
  - Beats are never dropped, duplicated or reordered.
- Outputs are registered. o_pe_valid is all zeros whenever o_dist_valid = 0.
- Multicast: any number of lanes may carry the same select.
- o_beat_cnt increments on each out_fire and wraps modulo 2^CNT_W with no saturation.
- Simultaneous events:
  - accept and out_fire in the same cycle with both stages full: pass-through, occupancy unchanged;
  - cfg load and accept in the same cycle: see the Config rules above.

Test Plan:
- Reset config with data element k = k+100 and i_dist_ready = 1: lane p = 100 + (p mod 32); o_pe_valid = all ones; first o_dist_valid 2 edges after accept; o_beat_cnt = 1 after handoff.
- Broadcast: cfg all selects = 7, then stream 10 back-to-back beats with element 7 = beat index: every lane equals the beat index; one beat per cycle; o_beat_cnt = 10.
- Backpressure: hold i_dist_ready = 0 while sending 3 beats: only 2 accepted and o_data_ready = 0; outputs stable for 5 cycles; release, and beats emerge in order with no loss.
- Out-of-range and mask: lane 3 select = 40 and lane 5 mask = 0: lane 3 data = 0 with o_sel_err[3] = 1; lane 5 data = 0 with o_pe_valid[5] = 0 and o_sel_err[5] = 0; all other lanes normal.
- Config race: i_cfg_valid (all selects = 1) on the same edge as beat A, beat B on the next edge: A routed with the old config, B with all lanes = element 1.
- Async reset: assert rst low mid-stream with both stages full: o_dist_valid, o_beat_cnt and o_dist_bus go to 0 immediately without waiting for a clock edge; after release, the first output comes only from newly accepted data.
